// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, reset PC and fetch FSM state encoding
package instr_fetch_pkg;
    localparam int DEF_WIDTH = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
endpackage

// File: rtl/instr_fetch_pc_reg.sv
// instr_fetch_pc_reg: loadable, wrapping incrementing program counter
module instr_fetch_pc_reg #(
    parameter int W = 16,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] target,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= RESET_VAL;
        else if (load) q <= target;
        else if (inc) q <= q + W'(1);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: FETCH/WAIT/HOLD instruction fetch unit with instruction register
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] instruction,
    output logic             instr_valid,
    input  logic             instr_done,
    input  logic             pc_load,
    input  logic [WIDTH-1:0] pc_target,
    output logic [WIDTH-1:0] link_pc
);
    logic [1:0] state, state_next;
    logic [WIDTH-1:0] pc;
    logic take, redirect;

    assign take = (state == WAIT) && mem_ready;
    assign redirect = (state == HOLD) && instr_done && pc_load;

    instr_fetch_pc_reg #(.W(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk),
        .reset(reset),
        .inc(take),
        .load(redirect),
        .target(pc_target),
        .q(pc)
    );

    always_comb
        state_next = (state == FETCH) ? (halt ? FETCH : WAIT) :
                     (state == WAIT)  ? (mem_ready ? HOLD : WAIT) :
                     (state == HOLD)  ? (instr_done ? FETCH : HOLD) : FETCH;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FETCH;
        else state <= state_next;

    always_ff @(posedge clk or posedge reset)
        if (reset) instruction <= '0;
        else if (take) instruction <= mem_rdata;

    assign mem_rd = (state == WAIT);
    assign instr_valid = (state == HOLD);
    assign mem_addr = pc;
    assign link_pc = pc;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with queued expectations checked by a fetch monitor
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset, halt, mem_rd, mem_ready, instr_valid, instr_done, pc_load;
    logic [15:0] mem_addr, mem_rdata, instruction, pc_target, link_pc;
    int checks = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic prev_valid = 1'b0;

    instr_fetch dut (
        .clk(clk), .reset(reset), .halt(halt), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instruction(instruction),
        .instr_valid(instr_valid), .instr_done(instr_done), .pc_load(pc_load),
        .pc_target(pc_target), .link_pc(link_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // a new fetched word is presented on the first cycle instr_valid is high
    always @(negedge clk) begin
        if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) chk("unexpected_fetch", {instruction, link_pc}, 32'hxxxxxxxx);
            else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("mon_instruction", {16'h0, instruction}, {16'h0, e[31:16]});
                chk("mon_link_pc", {16'h0, link_pc}, {16'h0, e[15:0]});
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        reset = 1'b1; halt = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        instr_done = 1'b0; pc_load = 1'b0; pc_target = '0;
        tick(); tick();
        chk("rst_mem_rd", {31'h0, mem_rd}, 0);
        chk("rst_valid", {31'h0, instr_valid}, 0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 0);
        chk("rst_link_pc", {16'h0, link_pc}, 0);
        chk("rst_instruction", {16'h0, instruction}, 0);
        // first fetch at RESET_PC
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h0513;
        exp_q.push_back({16'h0513, 16'h0001});
        tick();
        chk("f1_mem_rd", {31'h0, mem_rd}, 1);
        chk("f1_mem_addr", {16'h0, mem_addr}, 0);
        tick();
        mem_ready = 1'b0;
        chk("f1_valid", {31'h0, instr_valid}, 1);
        chk("f1_mem_rd_hold", {31'h0, mem_rd}, 0);
        // hold stays stable; pc_load without instr_done is ignored
        pc_load = 1'b1; pc_target = 16'h7777;
        tick();
        pc_load = 1'b0;
        tick();
        chk("hold_valid", {31'h0, instr_valid}, 1);
        chk("hold_instruction", {16'h0, instruction}, 16'h0513);
        chk("hold_link_pc", {16'h0, link_pc}, 16'h0001);
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        chk("retire_valid", {31'h0, instr_valid}, 0);
        chk("retire_mem_addr", {16'h0, mem_addr}, 16'h0001);
        // memory withholds ready for three WAIT cycles
        mem_rdata = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_mem_rd", {31'h0, mem_rd}, 1);
            chk("wait_mem_addr", {16'h0, mem_addr}, 16'h0001);
            chk("wait_instruction", {16'h0, instruction}, 16'h0513);
        end
        mem_ready = 1'b1;
        exp_q.push_back({16'h1234, 16'h0002});
        tick();
        mem_ready = 1'b0;
        // branch redirect
        instr_done = 1'b1; pc_load = 1'b1; pc_target = 16'h0040;
        tick();
        instr_done = 1'b0; pc_load = 1'b0;
        chk("br_fetch_mem_rd", {31'h0, mem_rd}, 0);
        chk("br_fetch_addr", {16'h0, mem_addr}, 16'h0040);
        tick();
        chk("br_wait_mem_rd", {31'h0, mem_rd}, 1);
        chk("br_wait_addr", {16'h0, mem_addr}, 16'h0040);
        mem_ready = 1'b1; mem_rdata = 16'hABCD;
        exp_q.push_back({16'hABCD, 16'h0041});
        tick();
        mem_ready = 1'b0;
        // pc wraps from FFFF
        instr_done = 1'b1; pc_load = 1'b1; pc_target = 16'hFFFF;
        tick();
        instr_done = 1'b0; pc_load = 1'b0;
        tick();
        chk("wrap_addr", {16'h0, mem_addr}, 16'hFFFF);
        mem_ready = 1'b1; mem_rdata = 16'h5A5A;
        exp_q.push_back({16'h5A5A, 16'h0000});
        tick();
        mem_ready = 1'b0;
        chk("wrap_link_pc", {16'h0, link_pc}, 16'h0000);
        // halt holds FETCH; mem_ready outside WAIT is ignored
        halt = 1'b1; instr_done = 1'b1;
        tick();
        instr_done = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_mem_rd", {31'h0, mem_rd}, 0);
            chk("halt_valid", {31'h0, instr_valid}, 0);
        end
        chk("halt_instruction", {16'h0, instruction}, 16'h5A5A);
        chk("halt_pc", {16'h0, link_pc}, 16'h0000);
        halt = 1'b0; mem_ready = 1'b0;
        tick();
        chk("unhalt_mem_rd", {31'h0, mem_rd}, 1);
        chk("unhalt_addr", {16'h0, mem_addr}, 16'h0000);
        // halt raised mid-WAIT does not abort the read
        halt = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h0777;
        exp_q.push_back({16'h0777, 16'h0001});
        tick();
        halt = 1'b0; mem_ready = 1'b0;
        chk("halt_wait_valid", {31'h0, instr_valid}, 1);
        // reset mid-WAIT with late mem_ready
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        tick();
        chk("pre_rst_mem_rd", {31'h0, mem_rd}, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_rd", {31'h0, mem_rd}, 0);
        chk("arst_mem_addr", {16'h0, mem_addr}, 0);
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        tick(); tick();
        chk("arst_instruction", {16'h0, instruction}, 0);
        chk("arst_link_pc", {16'h0, link_pc}, 0);
        chk("arst_valid", {31'h0, instr_valid}, 0);
        reset = 1'b0; mem_ready = 1'b0;
        tick();
        chk("post_rst_mem_rd", {31'h0, mem_rd}, 1);
        chk("post_rst_instruction", {16'h0, instruction}, 0);
        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter WIDTH, 16, instruction/address/data width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 halt  input  1  when high, no new fetch is started.
REQ-006 mem_addr  output  16  word address to instruction memory.
REQ-007 mem_rd  output  1  read request to instruction memory.
REQ-008 mem_ready  input  1  memory has valid data on mem_rdata this cycle.
REQ-009 mem_rdata  input  16  instruction word from memory.
REQ-010 instruction  output  16  instruction register contents, feeds the control FSM.
REQ-011 instr_valid  output  1  instruction holds a fetched, not-yet-retired word.
REQ-012 instr_done  input  1  control FSM retires the current instruction.
REQ-013 pc_load  input  1  with instr_done, redirect fetch to pc_target.
REQ-014 pc_target  input  16  branch/jump destination address.
REQ-015 link_pc  output  16  current PC (address after the held instruction), for JAL link.

Function
REQ-016 FSM states SHALL be FETCH, WAIT, HOLD; Moore outputs only.
REQ-017 FETCH: mem_rd=0; if halt=0 go WAIT, else stay FETCH.
REQ-018 WAIT: mem_rd=1, mem_addr=pc; stay until mem_ready=1.
REQ-019 WAIT with mem_ready=1: instruction<=mem_rdata, pc<=pc+1, go HOLD, same edge.
REQ-020 PC increment SHALL wrap modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-021 mem_addr SHALL equal pc in every state; mem_rd SHALL be 1 only in WAIT.
REQ-022 HOLD: instr_valid=1, instruction and pc stable while instr_done=0.
REQ-023 HOLD with instr_done=1 and pc_load=0: go FETCH, pc unchanged.
REQ-024 HOLD with instr_done=1 and pc_load=1: pc<=pc_target, go FETCH.
REQ-025 instr_done and pc_load SHALL be ignored outside HOLD; pc_load without instr_done SHALL be ignored.
REQ-026 mem_ready SHALL be ignored outside WAIT.
REQ-027 halt SHALL only block FETCH->WAIT; a WAIT in progress completes.
REQ-028 instr_valid SHALL be 1 exactly in HOLD; deasserts the cycle after retirement.
REQ-029 Minimum fetch latency: FETCH exit to instr_valid=1 is 2 cycles (FETCH, WAIT with mem_ready).
REQ-030 link_pc SHALL equal pc at all times.

Reset
REQ-031 reset SHALL asynchronously force state FETCH, pc=RESET_PC, instruction=16'h0000.
REQ-032 During and after reset: mem_rd=0, instr_valid=0, mem_addr=RESET_PC, link_pc=RESET_PC.
REQ-033 Reset mid-WAIT SHALL abandon the read; a late mem_ready SHALL not update instruction.

Structure
REQ-034 Shared package SHALL hold fetch state encoding (2-bit), WIDTH, RESET_PC default.
REQ-035 One sub-module pc_reg (16-bit loadable, incrementing register with async reset) is natural; the FSM and instruction register stay in instr_fetch.

Verification
REQ-036 Reset release, halt=0, mem_ready=1, mem_rdata=16'h0513 -> mem_rd=1 at addr 0, then instruction=16'h0513, instr_valid=1, link_pc=1.
REQ-037 mem_ready withheld 3 cycles in WAIT -> mem_rd=1, mem_addr stable 3+ cycles; instruction unchanged until ready.
REQ-038 HOLD, instr_done=1, pc_load=1, pc_target=16'h0040 -> next mem_addr=16'h0040 with mem_rd=1.
REQ-039 pc=16'hFFFF fetch completes -> link_pc=16'h0000.
REQ-040 halt=1 in FETCH for 5 cycles -> mem_rd=0 throughout; halt=0 -> WAIT next cycle.
REQ-041 Reset asserted mid-WAIT, mem_ready pulses during reset -> instruction=16'h0000, pc=RESET_PC, instr_valid=0.
